// File: rtl/step_decoder.sv
// rtl/step_decoder.sv - STEP/DIR/ENN receiver: sync, glitch filter, position count, step period.
// Optional STEPDEC_DEDGE_EN: count both STEP edges as steps (dual-edge stepping).
module step_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int DIR_SETUP  = 8,
  parameter int PERIOD_W   = 24
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                step_i,
  input  logic                dir_i,
  input  logic                enn_i,
  input  logic                pos_clear_i,
  input  logic                err_clear_i,
  output logic                step_strobe_o,
  output logic [31:0]         position_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o,
  output logic                dir_err_o
);

  localparam logic [7:0]          FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [7:0]          DSETUP    = 8'(DIR_SETUP);
  localparam logic [PERIOD_W-1:0] PMAX      = '1;
  localparam logic [PERIOD_W-1:0] PONE      = {{(PERIOD_W-1){1'b0}}, 1'b1};

  logic [1:0]          step_sync_q, dir_sync_q, enn_sync_q;
  logic                step_f_q, step_f_d;
  logic                step_f_prev_q;
  logic [7:0]          filt_cnt_q, filt_cnt_d;
  logic                dir_prev_q;
  logic [7:0]          dir_stable_q, dir_stable_d;
  logic                strobe_q, strobe_d;
  logic [31:0]         position_q, position_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pvalid_q, pvalid_d;
  logic                armed_q, armed_d;
  logic                err_q, err_d;

  logic step_s, dir_s, en, edge_seen, step_ev;

  assign step_s = step_sync_q[1];
  assign dir_s  = dir_sync_q[1];
  assign en     = ~enn_sync_q[1];

`ifdef STEPDEC_DEDGE_EN
  assign edge_seen = step_f_q ^ step_f_prev_q;
`else
  assign edge_seen = step_f_q & ~step_f_prev_q;
`endif
  assign step_ev = en & edge_seen;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      step_sync_q   <= '0;
      dir_sync_q    <= '0;
      enn_sync_q    <= '0;
      step_f_q      <= 1'b0;
      step_f_prev_q <= 1'b0;
      filt_cnt_q    <= '0;
      dir_prev_q    <= 1'b0;
      dir_stable_q  <= '0;
      strobe_q      <= 1'b0;
      position_q    <= '0;
      cnt_q         <= '0;
      period_q      <= '0;
      pvalid_q      <= 1'b0;
      armed_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      step_sync_q   <= {step_sync_q[0], step_i};
      dir_sync_q    <= {dir_sync_q[0], dir_i};
      enn_sync_q    <= {enn_sync_q[0], enn_i};
      step_f_q      <= step_f_d;
      step_f_prev_q <= step_f_q;
      filt_cnt_q    <= filt_cnt_d;
      dir_prev_q    <= dir_s;
      dir_stable_q  <= dir_stable_d;
      strobe_q      <= strobe_d;
      position_q    <= position_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      pvalid_q      <= pvalid_d;
      armed_q       <= armed_d;
      err_q         <= err_d;
    end
  end

  // Level filter: step_s must disagree with step_f for FILTER_LEN cycles in a row.
  always_comb begin
    filt_cnt_d = '0;
    step_f_d   = step_f_q;
    if (step_s != step_f_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        step_f_d = step_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    dir_stable_d = dir_stable_q;
    if (dir_s != dir_prev_q) begin
      dir_stable_d = '0;
    end else if (dir_stable_q < DSETUP) begin
      dir_stable_d = dir_stable_q + 8'd1;
    end

    err_d = err_q;
    if (step_ev && (dir_stable_q < DSETUP)) begin
      err_d = 1'b1;
    end else if (err_clear_i) begin
      err_d = 1'b0;
    end

    strobe_d   = step_ev;
    position_d = position_q;
    if (pos_clear_i) begin
      position_d = '0;
    end else if (step_ev) begin
      position_d = dir_s ? position_q - 32'd1 : position_q + 32'd1;
    end
  end

  // Interval counter; a saturated counter means the axis stalled, so disarm.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    armed_d  = armed_q;
    if (!en) begin
      cnt_d    = '0;
      pvalid_d = 1'b0;
      armed_d  = 1'b0;
    end else if (step_ev) begin
      period_d = cnt_q;
      cnt_d    = PONE;
      pvalid_d = armed_q;
      armed_d  = 1'b1;
    end else if (cnt_q == PMAX) begin
      pvalid_d = 1'b0;
      armed_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + PONE;
    end
  end

  assign step_strobe_o  = strobe_q;
  assign position_o     = position_q;
  assign period_o       = period_q;
  assign period_valid_o = pvalid_q;
  assign dir_err_o      = err_q;

endmodule

// File: tb/tb_step_decoder.sv
// tb/tb_step_decoder.sv - directed vector bench for step_decoder.
module tb_step_decoder;

  localparam int F = 4;
`ifdef STEPDEC_DEDGE_EN
  localparam int E = 2;
`else
  localparam int E = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_i, step_i, dir_i, enn_i, pos_clear_i, err_clear_i;
  logic        step_strobe_o, period_valid_o, dir_err_o;
  logic [31:0] position_o;
  logic [23:0] period_o;

  step_decoder #(.FILTER_LEN(F), .DIR_SETUP(8), .PERIOD_W(24)) dut (
    .clk_i(clk), .reset_i(reset_i), .step_i(step_i), .dir_i(dir_i), .enn_i(enn_i),
    .pos_clear_i(pos_clear_i), .err_clear_i(err_clear_i),
    .step_strobe_o(step_strobe_o), .position_o(position_o), .period_o(period_o),
    .period_valid_o(period_valid_o), .dir_err_o(dir_err_o)
  );

  always #5 clk = ~clk;

  int strobe_cnt = 0;
  always @(negedge clk) if (step_strobe_o) strobe_cnt++;

  typedef struct {
    int   hi;
    int   per;
    int   n;
    logic dir;
    logic enn;
    int   exp_strobes;
    int   exp_dpos;
    int   exp_pv;
    int   exp_period;
    int   exp_err;
  } vec_t;

  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pos = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic pulses(input int hi, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      step_i = 1'b1;
      repeat (hi) @(negedge clk);
      step_i = 1'b0;
      repeat (per - hi) @(negedge clk);
    end
  endtask

  task automatic wait_strobe(output int lat);
    bit found = 0;
    lat = 0;
    while (!found && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (step_strobe_o) found = 1;
    end
  endtask

  initial begin
    int s0, lat;
    vecs[0] = '{10, 30, 5, 1'b0, 1'b0, 5*E, 5*E, 1, (E == 1) ? 30 : 10, 0};
    vecs[1] = '{3, 20, 1, 1'b0, 1'b0, 0, 0, -1, -1, 0};
    vecs[2] = '{10, 30, 3, 1'b0, 1'b1, 0, 0, 0, (E == 1) ? 30 : 10, 0};
    vecs[3] = '{25, 50, 2, 1'b0, 1'b0, 2*E, 2*E, 1, (E == 1) ? 50 : 25, 0};
    vecs[4] = '{10, 30, 3, 1'b1, 1'b0, 3*E, -3*E, 1, (E == 1) ? 30 : 10, 0};
    vecs[5] = '{4, 8, 3, 1'b0, 1'b0, 3*E, 3*E, 1, (E == 1) ? 8 : 4, 0};

    reset_i = 1'b1; step_i = 1'b0; dir_i = 1'b0; enn_i = 1'b0;
    pos_clear_i = 1'b0; err_clear_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_strobe", step_strobe_o, 0);
    check("rst_position", position_o, 0);
    check("rst_period", period_o, 0);
    check("rst_pvalid", period_valid_o, 0);
    check("rst_dir_err", dir_err_o, 0);
    repeat (20) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      dir_i = vecs[v].dir;
      enn_i = vecs[v].enn;
      repeat (20) @(negedge clk);
      s0 = strobe_cnt;
      pulses(vecs[v].hi, vecs[v].per, vecs[v].n);
      repeat (20) @(negedge clk);
      exp_pos = exp_pos + 32'(vecs[v].exp_dpos);
      check($sformatf("v%0d_strobes", v), 64'(strobe_cnt - s0), 64'(vecs[v].exp_strobes));
      check($sformatf("v%0d_position", v), position_o, exp_pos);
      check($sformatf("v%0d_dir_err", v), dir_err_o, 64'(vecs[v].exp_err));
      if (vecs[v].exp_pv >= 0)
        check($sformatf("v%0d_pvalid", v), period_valid_o, 64'(vecs[v].exp_pv));
      if (vecs[v].exp_period >= 0)
        check($sformatf("v%0d_period", v), period_o, 64'(vecs[v].exp_period));
    end

    // Latency from the first edge sampling STEP high to the strobe.
    step_i = 1'b1;
    wait_strobe(lat);
    check("latency", 64'(lat), 64'(F + 3));
    exp_pos = exp_pos + 32'd1;
    check("latency_position", position_o, exp_pos);
    repeat (6) @(negedge clk);
    step_i = 1'b0;
    repeat (20) @(negedge clk);
    exp_pos = exp_pos + 32'(E - 1);

    // DIR flipped 2 cycles before STEP rises: setup violation, step still counted down.
    dir_i = 1'b1;
    repeat (2) @(negedge clk);
    pulses(10, 30, 1);
    repeat (10) @(negedge clk);
    exp_pos = exp_pos - 32'(E);
    check("dir_setup_position", position_o, exp_pos);
    check("dir_setup_err", dir_err_o, 1);
    err_clear_i = 1'b1;
    @(negedge clk);
    err_clear_i = 1'b0;
    check("err_clear", dir_err_o, 0);
    dir_i = 1'b0;
    repeat (20) @(negedge clk);

    // Wrap 0x7FFFFFFF -> 0x80000000.
    force dut.position_q = 32'h7FFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.position_q;
    step_i = 1'b1;
    wait_strobe(lat);
    check("wrap_position", position_o, 32'h8000_0000);
    repeat (6) @(negedge clk);
    step_i = 1'b0;
    repeat (20) @(negedge clk);
    check("wrap_after", position_o, 32'h8000_0000 + 32'(E - 1));

    // pos_clear in the same cycle as the event: strobe pulses, count discarded.
    step_i = 1'b1;
    repeat (F + 2) @(posedge clk);
    @(negedge clk);
    pos_clear_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pos_clear_i = 1'b0;
    check("clr_strobe", step_strobe_o, 1);
    check("clr_position", position_o, 0);
    repeat (5) @(negedge clk);
    step_i = 1'b0;
    repeat (20) @(negedge clk);
    check("clr_after", position_o, 32'(E - 1));

    // Reset while STEP is high: first accepted level counts as one event, only arms period.
    step_i = 1'b1;
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    s0 = strobe_cnt;
    repeat (20) @(negedge clk);
    check("rst_mid_strobes", 64'(strobe_cnt - s0), 1);
    check("rst_mid_position", position_o, 1);
    check("rst_mid_pvalid", period_valid_o, 0);
    step_i = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_decoder.md
# step_decoder

Receive side of the step/dir motor interface. Takes external, asynchronous STEP/DIR/ENN lines (as driven by a step generator or an external motion controller) and produces a filtered step strobe, a signed 32-bit position count and a step-interval measurement. Sits between the FPGA input pins and the position/telemetry register bank, mirroring the generator's position count on the far end of the link.

## Interface

- FILTER_LEN, 4: consecutive synchronized samples required before a STEP level change is accepted (1..255).
- DIR_SETUP, 8: minimum cycles DIR must be stable before an accepted step edge (1..255).
- PERIOD_W, 24: width of the step-interval counter/output.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- step_in  in  1  external STEP, asynchronous
- dir_in  in  1  external DIR, asynchronous; 0 = count up, 1 = count down
- enn_in  in  1  external enable, active-low, asynchronous
- pos_clear  in  1  synchronous position clear, one-cycle pulse
- err_clear  in  1  clears dir_err
- step_strobe  out  1  one-cycle pulse per accepted step event
- position  out  32  signed step count
- period  out  PERIOD_W  cycles between last two step events
- period_valid  out  1  period holds a valid measurement
- dir_err  out  1  sticky DIR setup violation

## Operation

- step_in, dir_in, enn_in each pass a 2-flop synchronizer; all logic uses synchronized versions (step_s, dir_s, en = !enn_s).
- Filter: registered level step_f; counter counts cycles with step_s != step_f, clears when equal; on reaching FILTER_LEN, step_f <= step_s, counter clears. Pulses/glitches shorter than FILTER_LEN cycles are never seen.
- Step event: rising edge of step_f while en = 1. Edges while en = 0 discarded; filter keeps running.
- On event: position += 1 if dir_s = 0, else -= 1; step_strobe = 1 for one cycle. 32-bit two's-complement wrap (0x7FFFFFFF + 1 -> 0x80000000), no saturation.
- DIR setup: dir_stable counter clears when dir_s changes, else increments, saturating at DIR_SETUP. Event with dir_stable < DIR_SETUP sets dir_err; step still counted with current dir_s. dir_err clears only on err_clear or reset; set wins if err_clear and a violation coincide.
- pos_clear: position <= 0; an event in the same cycle is discarded from the count (strobe still pulses).
- Period: cnt increments each cycle, saturating at 2^PERIOD_W-1. On event: period <= cnt, cnt <= 1; period_valid <= 1 only if a previous event has been recorded since reset/enable (first event only arms). cnt reaching saturation clears period_valid and disarms (stall). en = 0 clears cnt, period_valid and arm flag; period holds last value.

## Timing

- Reset values: step_strobe 0, position 0, period 0, period_valid 0, dir_err 0; synchronizers, filter, step_f, counters 0.
- Latency: step_strobe and position update registered exactly FILTER_LEN+3 cycles after the first clk edge sampling step_in high (2 sync + FILTER_LEN filter + 1 output register).
- Steps N cycles apart (N >= 2*FILTER_LEN) give period = N.
- Minimum accepted step: FILTER_LEN high, FILTER_LEN low.
- Reset mid-pulse: all state cleared; a STEP already high at reset release is accepted as level after FILTER_LEN+2 cycles but produces an event only on a later rising edge of step_f (step_f resets 0, so this first transition counts as one event if en = 1).

## Configuration

- STEPDEC_DEDGE_EN defined: both rising and falling edges of step_f are step events (dual-edge stepping); period measures edge-to-edge interval.
- Not defined: rising edges only; falling edges ignored.

## Test plan

- Reset, en = 1, dir = 0, 5 STEP pulses 10 cycles high / 30 cycles period -> position = 5, 5 strobes, each FILTER_LEN+3 cycles after rise, period = 30, period_valid = 1 after 2nd pulse.
- STEP glitch 3 cycles high (FILTER_LEN = 4) -> no strobe, position unchanged.
- dir = 1 toggled 2 cycles before accepted edge (DIR_SETUP = 8) -> position -1, dir_err = 1; err_clear -> dir_err = 0.
- position preloaded to 0x7FFFFFFF via steps/clear sequence (force in bench), one up step -> 0x80000000; pos_clear coincident with event -> position 0.
- enn_in = 1 during 3 pulses -> position unchanged, period_valid = 0; re-enable, 2 pulses 50 apart -> period = 50.
- STEPDEC_DEDGE_EN defined: 4 pulses -> position = 8, 8 strobes.
